// File: rtl/as13_obs_decoder.sv
// Runtime integrity monitor for the as13 output bus: decodes each observed word to a codeword index
// and checks the codeword sequence. Optional error-word capture is enabled by AS13_ERR_CAPTURE_EN.
module as13_obs_decoder #(
  parameter int unsigned ALARM_THRESH = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             obs_valid_i,
  input  logic [24:0]      obs_y_i,
  output logic             code_valid_o,
  output logic [3:0]       code_o,
  output logic             err_illegal_o,
  output logic             err_seq_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic             alarm_o
`ifdef AS13_ERR_CAPTURE_EN
  ,
  output logic [24:0]      cap_word_o,
  output logic             cap_valid_o
`endif
);

  // state     | meaning
  // ST_IDLE   | no word seen since reset; first word is not sequence-checked
  // ST_TRACK  | normal tracking; Z only legal directly after D
  // ST_EXP_KF | one K seen; expecting K or F
  // ST_EXP_F  | K,K seen; expecting F
  // ST_EXP_A  | Z seen; expecting A
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_TRACK  = 3'd1;
  localparam logic [2:0] ST_EXP_KF = 3'd2;
  localparam logic [2:0] ST_EXP_F  = 3'd3;
  localparam logic [2:0] ST_EXP_A  = 3'd4;

  localparam logic [3:0] CW_Z = 4'd0;
  localparam logic [3:0] CW_A = 4'd1;
  localparam logic [3:0] CW_D = 4'd4;
  localparam logic [3:0] CW_F = 4'd6;
  localparam logic [3:0] CW_K = 4'd11;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] THRESH_CW = CNT_W'(ALARM_THRESH);

  logic [2:0]       state_q, state_d;
  logic [3:0]       prev_q, prev_d;
  logic             code_valid_q;
  logic [3:0]       code_q, code_d;
  logic             err_illegal_q, err_seq_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             alarm_q, alarm_d;

  logic       match;
  logic [3:0] dec_code;
  logic       seq_err;
  logic       word_err;

  // Exact-match decode; bit0 of obs_y is y1.
  always_comb begin
    match    = 1'b1;
    dec_code = CW_Z;
    case (obs_y_i)
      25'h0000000: dec_code = 4'd0;
      25'h0000400: dec_code = 4'd1;
      25'h000007A: dec_code = 4'd2;
      25'h0402078: dec_code = 4'd3;
      25'h0010100: dec_code = 4'd4;
      25'h000C088: dec_code = 4'd5;
      25'h004000E: dec_code = 4'd6;
      25'h08000C8: dec_code = 4'd7;
      25'h000403A: dec_code = 4'd8;
      25'h0000300: dec_code = 4'd9;
      25'h010200C: dec_code = 4'd10;
      25'h000084A: dec_code = 4'd11;
      25'h0003038: dec_code = 4'd12;
      25'h02A8008: dec_code = 4'd13;
      25'h1020003: dec_code = 4'd14;
      25'h00A000A: dec_code = 4'd15;
      default:     match    = 1'b0;
    endcase
  end

  // Checker only advances on legal words; unmatched words leave state and history untouched.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    seq_err = 1'b0;
    if (obs_valid_i && match) begin
      prev_d = dec_code;
      case (state_q)
        ST_IDLE, ST_TRACK: begin
          seq_err = (state_q == ST_TRACK) && (dec_code == CW_Z) && (prev_q != CW_D);
          if (dec_code == CW_K)      state_d = ST_EXP_KF;
          else if (dec_code == CW_Z) state_d = ST_EXP_A;
          else                       state_d = ST_TRACK;
        end
        ST_EXP_KF: begin
          if (dec_code == CW_K) begin
            state_d = ST_EXP_F;
          end else begin
            seq_err = (dec_code != CW_F);
            state_d = ST_TRACK;
          end
        end
        ST_EXP_F: begin
          seq_err = (dec_code != CW_F);
          state_d = ST_TRACK;
        end
        ST_EXP_A: begin
          seq_err = (dec_code != CW_A);
          state_d = ST_TRACK;
        end
        default: state_d = ST_TRACK;
      endcase
    end
  end

  always_comb begin
    word_err = obs_valid_i && (!match || seq_err);
    code_d   = obs_valid_i ? dec_code : code_q;
    cnt_d    = cnt_q;
    if (word_err && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
    alarm_d  = alarm_q || (cnt_d >= THRESH_CW);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      prev_q        <= CW_Z;
      code_valid_q  <= 1'b0;
      code_q        <= 4'd0;
      err_illegal_q <= 1'b0;
      err_seq_q     <= 1'b0;
      cnt_q         <= '0;
      alarm_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      code_valid_q  <= obs_valid_i;
      code_q        <= code_d;
      err_illegal_q <= obs_valid_i && !match;
      err_seq_q     <= seq_err;
      cnt_q         <= cnt_d;
      alarm_q       <= alarm_d;
    end
  end

  assign code_valid_o  = code_valid_q;
  assign code_o        = code_q;
  assign err_illegal_o = err_illegal_q;
  assign err_seq_o     = err_seq_q;
  assign err_count_o   = cnt_q;
  assign alarm_o       = alarm_q;

`ifdef AS13_ERR_CAPTURE_EN
  logic [24:0] cap_word_q;
  logic        cap_valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cap_word_q  <= '0;
      cap_valid_q <= 1'b0;
    end else if (word_err && !cap_valid_q) begin
      cap_word_q  <= obs_y_i;
      cap_valid_q <= 1'b1;
    end
  end

  assign cap_word_o  = cap_word_q;
  assign cap_valid_o = cap_valid_q;
`endif

endmodule
